// File: rtl/jk_excite_gen.sv
// Drives a downstream JK flop to a WIDTH-bit target pattern, one bit per cycle (LSB first).
// Tracks the flop's expected Q in a shadow bit and flags any disagreement with the fed-back Q.
module jk_excite_gen #(
    parameter int WIDTH       = 8,
    parameter bit TOGGLE_PREF = 1'b1
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             J,
    output logic             K,
    output logic             jk_reset,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [3:0]       err_cnt,
    input  logic             mismatch_clr
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SHIFT,
        CHECK
    } state_t;

    localparam int             IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             shadow, shadow_nxt;
    logic             bit_nxt;
    logic             j_nxt, k_nxt, jk_reset_nxt, done_nxt;
    logic             cmp_fail;

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    // Next state, next index/shadow, and the excitation that will be presented during the
    // next cycle; J/K/jk_reset/done are then simply registered from these.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
        state_nxt    = state;
        idx_nxt      = idx;
        shadow_nxt   = shadow;
        j_nxt        = 1'b0;
        k_nxt        = 1'b0;

        unique case (state)
            IDLE: begin
                if (load_valid) state_nxt = INIT;
            end
            INIT: begin
                state_nxt  = SHIFT;
                idx_nxt    = '0;
                shadow_nxt = 1'b0;
            end
            SHIFT: begin
                shadow_nxt = data[idx];
                if (idx == LAST_IDX) begin
                    state_nxt = CHECK;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        bit_nxt = data[idx_nxt];
        if (state_nxt == SHIFT && bit_nxt != shadow_nxt) begin
            if (TOGGLE_PREF) begin
                j_nxt = 1'b1;
                k_nxt = 1'b1;
            end else begin
                j_nxt = bit_nxt;
                k_nxt = ~bit_nxt;
            end
        end

        jk_reset_nxt = (state_nxt == INIT);
        done_nxt     = (state_nxt == CHECK);
    end

    // Q seen during SHIFT/CHECK is the result of the previous edge, which the shadow mirrors.
    assign cmp_fail = ((state == SHIFT) || (state == CHECK)) && (q_fb != shadow);

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state    <= IDLE;
            data     <= '0;
            idx      <= '0;
            shadow   <= 1'b0;
            J        <= 1'b0;
            K        <= 1'b0;
            jk_reset <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            idx      <= idx_nxt;
            shadow   <= shadow_nxt;
            J        <= j_nxt;
            K        <= k_nxt;
            jk_reset <= jk_reset_nxt;
            done     <= done_nxt;
            if (state == IDLE && load_valid) data <= load_data;
        end
    end

    // A failure wins over a simultaneous clear: the flag stays up and the count restarts at 1.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            mismatch <= 1'b0;
            err_cnt  <= 4'd0;
        end else if (cmp_fail) begin
            mismatch <= 1'b1;
            if (mismatch_clr)          err_cnt <= 4'd1;
            else if (err_cnt != 4'd15) err_cnt <= err_cnt + 4'd1;
        end else if (mismatch_clr) begin
            mismatch <= 1'b0;
            err_cnt  <= 4'd0;
        end
    end

endmodule
